// File: rtl/smi_frame_arbiter_xn.sv
// N-way SMI frame arbiter: merges NumPorts upstream flit streams onto one
// downstream stream, granting one whole frame at a time (round-robin or fixed
// priority), with a 2-entry registered output buffer.
// Optional per-port last-flit counters: define SMI_FRAME_ARBITER_STATS_EN.
module smi_frame_arbiter_xn #(
  parameter int FlitWidth     = 16,
  parameter int NumPorts      = 4,
  parameter int PortIndexSize = 2,
  parameter int ArbMode       = 0
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NumPorts-1:0]             inReady,
  input  logic [NumPorts*8-1:0]           inEofc,
  input  logic [NumPorts*FlitWidth*8-1:0] inData,
  output logic [NumPorts-1:0]             inStop,
  output logic                            outReady,
  output logic [7:0]                      outEofc,
  output logic [FlitWidth*8-1:0]          outData,
  input  logic                            outStop,
  output logic [PortIndexSize-1:0]        grantPort
`ifdef SMI_FRAME_ARBITER_STATS_EN
  ,
  output logic [NumPorts*16-1:0]          frameCount,
  input  logic                            statClear
`endif
);

  localparam int DataW = FlitWidth * 8;

  typedef enum logic {Idle, Locked} stateT;

  stateT                    state;
  stateT                    nextState;
  logic [PortIndexSize-1:0] rrPtr;
  logic [PortIndexSize-1:0] winner;
  logic [PortIndexSize-1:0] nextPtr;
  logic                     anyReq;

  logic [DataW-1:0]         selData;
  logic [7:0]               selEofc;
  logic                     selReady;

  logic [DataW-1:0]         bufData [2];
  logic [7:0]               bufEofc [2];
  logic                     wrPtr;
  logic                     rdPtr;
  logic [1:0]               count;
  logic                     bufFull;
  logic                     push;
  logic                     pop;
  logic                     lastAcc;

  assign anyReq  = |inReady;
  assign bufFull = (count == 2'd2);
  assign push    = (state == Locked) && selReady && !bufFull;
  assign lastAcc = push && (selEofc != 8'd0);
  assign pop     = outReady && !outStop;
  assign nextPtr = (int'(grantPort) == NumPorts - 1) ? '0 : grantPort + 1'b1;

  // Route the granted port's flit toward the buffer write side.
  always_comb begin
    selData  = '0;
    selEofc  = '0;
    selReady = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      if (grantPort == PortIndexSize'(i)) begin
        selData  = inData[i*DataW +: DataW];
        selEofc  = inEofc[i*8 +: 8];
        selReady = inReady[i];
      end
    end
  end

  // Pick the winner: cyclic search from the pointer, or lowest index.
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NumPorts; k++) begin
      idx = (ArbMode == 0) ? int'(rrPtr) + k : k;
      if (idx >= NumPorts) idx = idx - NumPorts;
      if (!found && inReady[idx]) begin
        winner = PortIndexSize'(idx);
        found  = 1'b1;
      end
    end
  end

  // Next state and backpressure; inStop depends only on registered state.
  always_comb begin
    nextState = state;
    inStop    = '1;
    case (state)
      Idle: begin
        if (anyReq) nextState = Locked;
      end
      Locked: begin
        for (int i = 0; i < NumPorts; i++) begin
          if (grantPort == PortIndexSize'(i)) inStop[i] = bufFull;
        end
        if (lastAcc) nextState = Idle;
      end
      default: nextState = Idle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= Idle;
    else       state <= nextState;
  end

  // Grant capture in Idle; round-robin pointer advances past a finished frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grantPort <= '0;
      rrPtr     <= '0;
    end else begin
      if (state == Idle && anyReq) grantPort <= winner;
      if (lastAcc && ArbMode == 0) rrPtr <= nextPtr;
    end
  end

  // Output buffer control: pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wrPtr <= ~wrPtr;
      if (pop)  rdPtr <= ~rdPtr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output buffer storage; contents are masked at the output while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      bufData[wrPtr] <= selData;
      bufEofc[wrPtr] <= selEofc;
    end
  end

  assign outReady = (count != 2'd0);
  assign outData  = outReady ? bufData[rdPtr] : '0;
  assign outEofc  = outReady ? bufEofc[rdPtr] : '0;

`ifdef SMI_FRAME_ARBITER_STATS_EN
  logic [15:0] frameCnt [NumPorts];

  // Per-port last-flit counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NumPorts; i++) frameCnt[i] <= '0;
    end else if (statClear) begin
      for (int i = 0; i < NumPorts; i++) frameCnt[i] <= '0;
    end else if (lastAcc) begin
      for (int i = 0; i < NumPorts; i++) begin
        if (grantPort == PortIndexSize'(i)) frameCnt[i] <= frameCnt[i] + 16'd1;
      end
    end
  end

  // Flatten counters onto the output port.
  always_comb begin
    frameCount = '0;
    for (int i = 0; i < NumPorts; i++) frameCount[i*16 +: 16] = frameCnt[i];
  end
`endif

endmodule
